// File: rtl/sd_block_rx.sv
// SPI-mode SD single-block read data phase: token hunt, MSB-first block capture into 32-bit words, CRC16 capture.
// Words strobe one cycle after their last bit with fixed 32-cycle spacing; there is no back-pressure, so the consumer must keep up.
module sd_block_rx #(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 65535
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               D0_in,
  output logic                               D1,
  output logic                               CS,
  output logic [31:0]                        data,
  output logic                               data_valid,
  output logic [$clog2(BLOCK_BYTES/4)-1:0]   word_index,
  output logic [15:0]                        crc,
  output logic                               done,
  output logic [1:0]                         error
);

  localparam int WIW = $clog2(BLOCK_BYTES/4);
  localparam int BCW = $clog2(BLOCK_BYTES);
  localparam int TOW = ($clog2(TOKEN_TIMEOUT + 1) > 16) ? $clog2(TOKEN_TIMEOUT + 1) : 16;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLOCK_BYTES - 1);
  localparam logic [TOW-1:0] TMO_LAST  = TOW'(TOKEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TOKEN, S_DATA, S_CRC, S_DONE, S_ERR
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       w_err_next;
  logic [30:0]      r_shift;
  logic [2:0]       r_bit_cnt;
  logic [BCW-1:0]   r_byte_cnt;
  logic [WIW-1:0]   r_word_cnt;
  logic [TOW-1:0]   r_tmo_cnt;

  logic [7:0]       w_byte;
  logic             w_byte_end, w_word_end, w_block_end, w_crc_end, w_tmo_last;

  assign w_byte      = {r_shift[6:0], D0_in};
  assign w_byte_end  = (r_bit_cnt == 3'd7);
  assign w_word_end  = w_byte_end && (r_byte_cnt[1:0] == 2'd3);
  assign w_block_end = w_byte_end && (r_byte_cnt == LAST_BYTE);
  assign w_crc_end   = w_byte_end && (r_byte_cnt == BCW'(1));
  assign w_tmo_last  = (r_tmo_cnt >= TMO_LAST);

  assign D1   = 1'b1;
  assign CS   = !(r_state == S_WAIT_TOKEN || r_state == S_DATA || r_state == S_CRC);
  assign done = (r_state == S_DONE) || (r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_err_next = error;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_WAIT_TOKEN;
          w_err_next = 2'b00;
        end
      end
      S_WAIT_TOKEN: begin
        if (!start) begin
          w_next = S_IDLE;
        end else if (w_byte_end) begin
          if (w_byte == 8'hFE) begin
            w_next = S_DATA;
          end else if (w_byte[7:4] == 4'h0) begin
            w_next     = S_ERR;
            w_err_next = 2'b10;
          end else if (w_tmo_last) begin
            w_next     = S_ERR;
            w_err_next = 2'b01;
          end
        end
      end
      S_DATA: begin
        if (!start)          w_next = S_IDLE;
        else if (w_block_end) w_next = S_CRC;
      end
      S_CRC: begin
        if (!start)        w_next = S_IDLE;
        else if (w_crc_end) w_next = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (!start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters are reused across phases; each phase starts with bit/byte counters at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_tmo_cnt  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      word_index <= '0;
      crc        <= '0;
      error      <= 2'b00;
    end else begin
      data_valid <= 1'b0;
      error      <= w_err_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_tmo_cnt  <= '0;
            word_index <= '0;
            crc        <= '0;
          end
        end
        S_WAIT_TOKEN: begin
          if (start) begin
            r_shift   <= {r_shift[29:0], D0_in};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_end && r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (start) begin
            r_shift   <= {r_shift[29:0], D0_in};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_end) r_byte_cnt <= w_block_end ? '0 : r_byte_cnt + 1'b1;
            if (w_word_end) begin
              data       <= {r_shift, D0_in};
              data_valid <= 1'b1;
              word_index <= r_word_cnt;
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (start) begin
            crc       <= {crc[14:0], D0_in};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_end) r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
